deser_phase_ctrl: RTL and testbench
===================================

// Module: deser_phase_ctrl
// PURPOSE
//  Sampling-phase controller for the 8-phase oversampling front end of the deser400 path.
//  - Accumulates the per-phase transition flags (trans[7:0]) into a histogram over a fixed window.
//  - Picks the edge phase with the most transitions and selects the phase opposite it (edge+4 mod 8) as the data phase.
//  - Applies hysteresis before moving the phase; reports lock after N stable windows.
//  - Drives the phase select of the downstream bit picker.
// PARAMETERS
//  WIN_LOG2   8   window length = 2**WIN_LOG2 clk cycles; histogram counter width = WIN_LOG2+1
//  HYST       4   minimum count margin for the new edge over the current edge before the phase moves
//  LOCK_WINS  4   consecutive non-moving windows (with transitions) required to assert locked
// PORTS
//  clk          in   1  system clock (same clock as oversampling trans output, sclk[0] domain)
//  reset_n      in   1  asynchronous, active-low reset
//  enable       in   1  run controller; low = idle, histogram cleared
//  trans        in   8  transition flags from the oversampler; bit i = edge between sample i and i+1
//  force_en     in   1  override: phase <= force_phase every cycle, state machine held in IDLE
//  force_phase  in   3  forced phase value
//  phase        out  3  selected sampling phase
//  locked       out  1  phase stable for LOCK_WINS windows
//  phase_upd    out  1  one-cycle pulse when phase changes by decision (not by force)
// BEHAVIOUR
//  Reset (async, reset_n=0):
//   - phase=0, locked=0, phase_upd=0; state=IDLE; histogram=0; stable count=0.
//  States:
//   - IDLE:  entered on reset, !enable or force_en. Histogram and window counter are 0.
//            Goes to ACCUM on the first cycle with enable=1 and force_en=0.
//   - ACCUM: each cycle hist[i] += trans[i] for all i; window counter += 1.
//            After 2**WIN_LOG2 accumulated cycles, go to SCAN.
//            Counters cannot overflow (max 2**WIN_LOG2 fits WIN_LOG2+1 bits).
//   - SCAN:  8 cycles; index k = 0..7. If hist[k] > best_cnt, then best_cnt=hist[k], best_idx=k.
//            Strict >, so the lowest index wins on a tie. Then go to DECIDE.
//   - DECIDE: 1 cycle; cur_edge = (phase+4) mod 8, cand = (best_idx+4) mod 8.
//            Outcome chosen by the rules below. The same cycle clears the histogram, the window counter and best_cnt/best_idx, then returns to ACCUM.
//  Decision rules (DECIDE):
//   - best_cnt == 0 (no data): phase holds, stable count=0, locked=0.
//   - cand != phase and best_cnt >= hist[cur_edge] + HYST:
//     phase <= cand, phase_upd=1 for exactly one cycle, stable count=0, locked=0.
//   - Otherwise: stable count += 1, saturating at LOCK_WINS. locked=1 once stable count == LOCK_WINS.
//   - Comparison uses WIN_LOG2+2 bits (no wrap on the +HYST).
//  Timing:
//   - Decision latency from the first ACCUM cycle = 2**WIN_LOG2 + 8 + 1 cycles.
//   - phase/locked change registered on the clk edge ending DECIDE.
//  Boundary conditions:
//   - enable falling in any state: next cycle IDLE, histogram cleared, locked=0, stable=0, phase held.
//   - force_en: phase follows force_phase with 1-cycle latency; locked=0; phase_upd=0.
//     When released (with enable=1), a fresh window starts in ACCUM.
//   - reset_n asserted mid-SCAN/DECIDE: immediate return to reset values; no partial update.
//   - trans is sampled only in ACCUM; trans during SCAN/DECIDE is ignored (not counted in the next window).
// STRUCTURE
//  - Shared include deser_defs.vh: NPHASE=8, PHASE_W=3, state encodings (IDLE, ACCUM, SCAN, DECIDE).
//  - Sub-module deser_phase_hist: 8 counters of WIN_LOG2+1 bits.
//    Inputs: inc[7:0], clr, rd_idx[2:0]. Outputs: rd_cnt (read for SCAN), cnt of cur_edge.
//  - Top holds the FSM, window counter, best tracker, stable counter and output registers.
// TESTING (WIN_LOG2=4, HYST=4, LOCK_WINS=4 unless noted)
//  1. Reset: reset_n=0 with enable=1 and trans=8'hFF -> phase=0, locked=0, phase_upd=0; held until release.
//  2. trans=8'h08 constant, enable=1 -> after 16+8+1=25 cycles phase=7, single phase_upd pulse;
//     locked=1 at end of 4th following window, no further pulses.
//  3. Hysteresis: locked at phase=7; a window with hist[4]=9, hist[3]=7 (9 < 7+4) -> phase stays 7, locked stays 1.
//     A window with hist[4]=12, hist[3]=3 -> phase=0, phase_upd pulse, locked=0.
//  4. Tie: trans=8'h22 constant from reset -> edges 1 and 5 tie, lowest wins -> phase=5.
//  5. No data: locked at phase=7; trans=0 for a full window -> locked=0 after DECIDE, phase stays 7, no pulse.
//  6. Control: enable dropped mid-ACCUM -> IDLE next cycle, locked=0, histogram 0.
//     force_en=1, force_phase=3 -> phase=3 next cycle, no phase_upd.
//     Release -> full 25-cycle decision before the first change.

Source files
------------

// File: rtl/deser_phase_ctrl_pkg.sv
// deser_phase_ctrl_pkg: shared phase constants, controller states and the opposite-phase helper
package deser_phase_ctrl_pkg;
  localparam int NPHASE = 8;
  localparam int PHASE_W = 3;
  typedef enum logic [1:0] {IDLE, ACCUM, SCAN, DECIDE} state_t;
  function automatic logic [PHASE_W-1:0] opposite(input logic [PHASE_W-1:0] p);
    return p + PHASE_W'(NPHASE / 2);
  endfunction
endpackage

// File: rtl/deser_phase_ctrl_hist.sv
// deser_phase_ctrl_hist: per-phase transition histogram with a scan read port and an edge read port
//   clk, reset_n   clock, async active-low reset
//   inc            per-phase increment flags
//   clr            synchronous clear of all counters (wins over inc)
//   rd_idx/rd_cnt  scan read port
//   edge_idx/edge_cnt count of the current edge phase
module deser_phase_ctrl_hist
  import deser_phase_ctrl_pkg::*;
#(
  parameter int CW = 9
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NPHASE-1:0]  inc,
  input  logic               clr,
  input  logic [PHASE_W-1:0] rd_idx,
  input  logic [PHASE_W-1:0] edge_idx,
  output logic [CW-1:0]      rd_cnt,
  output logic [CW-1:0]      edge_cnt
);
  logic [CW-1:0] cnt_q [NPHASE];
  logic [CW-1:0] cnt_d [NPHASE];
  always_comb begin
    for (int i = 0; i < NPHASE; i++) cnt_d[i] = clr ? '0 : cnt_q[i] + CW'(inc[i]);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) for (int i = 0; i < NPHASE; i++) cnt_q[i] <= '0;
    else cnt_q <= cnt_d;
  end
  assign rd_cnt = cnt_q[rd_idx];
  assign edge_cnt = cnt_q[edge_idx];
endmodule

// File: rtl/deser_phase_ctrl.sv
// deser_phase_ctrl: picks the 8x-oversampling data phase opposite the busiest transition phase
//   clk, reset_n   clock, async active-low reset
//   enable         run controller; low idles and clears the histogram
//   trans          per-phase transition flags, counted only while accumulating
//   force_en/force_phase  override the phase, controller held idle
//   phase          selected sampling phase
//   locked         phase unchanged for LOCK_WINS windows that had transitions
//   phase_upd      one-cycle pulse when a decision moves the phase
module deser_phase_ctrl
  import deser_phase_ctrl_pkg::*;
#(
  parameter int WIN_LOG2  = 8,
  parameter int HYST      = 4,
  parameter int LOCK_WINS = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic [NPHASE-1:0]  trans,
  input  logic               force_en,
  input  logic [PHASE_W-1:0] force_phase,
  output logic [PHASE_W-1:0] phase,
  output logic               locked,
  output logic               phase_upd
);
  localparam int CW = WIN_LOG2 + 1;
  localparam int XW = WIN_LOG2 + 2;
  localparam int SW = $clog2(LOCK_WINS + 1);
  state_t state_q, state_d;
  logic [WIN_LOG2-1:0] wcnt_q, wcnt_d;
  logic [PHASE_W-1:0] k_q, k_d, best_idx_q, best_idx_d, phase_q, phase_d, cand;
  logic [CW-1:0] best_cnt_q, best_cnt_d, rd_cnt, edge_cnt;
  logic [SW-1:0] stable_q, stable_d;
  logic locked_q, locked_d, upd_q, upd_d, clr, move;
  logic [NPHASE-1:0] inc;
  deser_phase_ctrl_hist #(.CW(CW)) u_hist (
    .clk(clk), .reset_n(reset_n), .inc(inc), .clr(clr), .rd_idx(k_q),
    .edge_idx(opposite(phase_q)), .rd_cnt(rd_cnt), .edge_cnt(edge_cnt)
  );
  assign cand = opposite(best_idx_q);
  // widened so the hysteresis margin cannot wrap
  assign move = cand != phase_q && XW'(best_cnt_q) >= XW'(edge_cnt) + XW'(HYST);
  always_comb begin
    state_d = state_q;
    wcnt_d = wcnt_q;
    k_d = k_q;
    best_cnt_d = best_cnt_q;
    best_idx_d = best_idx_q;
    stable_d = stable_q;
    phase_d = phase_q;
    locked_d = locked_q;
    upd_d = 1'b0;
    clr = 1'b0;
    inc = '0;
    if (force_en || !enable) begin
      state_d = IDLE;
      wcnt_d = '0;
      k_d = '0;
      best_cnt_d = '0;
      best_idx_d = '0;
      stable_d = '0;
      locked_d = 1'b0;
      clr = 1'b1;
      phase_d = force_en ? force_phase : phase_q;
    end else begin
      case (state_q)
        IDLE: state_d = ACCUM;
        ACCUM: begin
          inc = trans;
          wcnt_d = wcnt_q + 1'b1;
          state_d = &wcnt_q ? SCAN : ACCUM;
        end
        SCAN: begin
          // strict > keeps the lowest index on a tie
          best_cnt_d = rd_cnt > best_cnt_q ? rd_cnt : best_cnt_q;
          best_idx_d = rd_cnt > best_cnt_q ? k_q : best_idx_q;
          k_d = k_q + 1'b1;
          state_d = &k_q ? DECIDE : SCAN;
        end
        default: begin
          clr = 1'b1;
          best_cnt_d = '0;
          best_idx_d = '0;
          state_d = ACCUM;
          if (best_cnt_q == '0) begin
            stable_d = '0;
            locked_d = 1'b0;
          end else if (move) begin
            phase_d = cand;
            upd_d = 1'b1;
            stable_d = '0;
            locked_d = 1'b0;
          end else begin
            stable_d = stable_q == SW'(LOCK_WINS) ? stable_q : stable_q + 1'b1;
            locked_d = stable_d == SW'(LOCK_WINS);
          end
        end
      endcase
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      wcnt_q <= '0;
      k_q <= '0;
      best_cnt_q <= '0;
      best_idx_q <= '0;
      stable_q <= '0;
      phase_q <= '0;
      locked_q <= 1'b0;
      upd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q <= wcnt_d;
      k_q <= k_d;
      best_cnt_q <= best_cnt_d;
      best_idx_q <= best_idx_d;
      stable_q <= stable_d;
      phase_q <= phase_d;
      locked_q <= locked_d;
      upd_q <= upd_d;
    end
  end
  assign phase = phase_q;
  assign locked = locked_q;
  assign phase_upd = upd_q;
endmodule

// File: tb/tb_deser_phase_ctrl.sv
// tb_deser_phase_ctrl: window-level reference model, per-cycle compare, directed and random stimulus
module tb_deser_phase_ctrl;
  localparam int WL = 4, HY = 4, LW = 4, WIN = 1 << WL, LAST = WIN + 8;
  logic clk = 0, reset_n = 1, enable = 0, force_en = 0;
  logic [7:0] trans = 0;
  logic [2:0] force_phase = 0;
  logic [2:0] phase;
  logic locked, phase_upd;
  int total = 0, passed = 0, pulses = 0;
  int m_phase = 0, m_locked = 0, m_upd = 0, m_stable = 0, m_run = -1;
  int h [8] = '{default: 0};
  int best, bi, cand, cur;
  deser_phase_ctrl #(.WIN_LOG2(WL), .HYST(HY), .LOCK_WINS(LW)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .trans(trans), .force_en(force_en),
    .force_phase(force_phase), .phase(phase), .locked(locked), .phase_upd(phase_upd)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
  endtask
  // m_run is the window position of the upcoming cycle, -1 while idle
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_phase = 0; m_locked = 0; m_upd = 0; m_stable = 0; m_run = -1;
      foreach (h[i]) h[i] = 0;
    end else begin
      m_upd = 0;
      if (force_en || !enable) begin
        if (force_en) m_phase = force_phase;
        m_locked = 0; m_stable = 0; m_run = -1;
        foreach (h[i]) h[i] = 0;
      end else if (m_run < 0) m_run = 0;
      else begin
        if (m_run < WIN) foreach (h[i]) h[i] += trans[i];
        if (m_run == LAST) begin
          best = 0; bi = 0;
          for (int k = 0; k < 8; k++) if (h[k] > best) begin best = h[k]; bi = k; end
          cand = (bi + 4) % 8;
          cur = (m_phase + 4) % 8;
          if (best == 0) begin m_stable = 0; m_locked = 0; end
          else if (cand != m_phase && best >= h[cur] + HY) begin
            m_phase = cand; m_upd = 1; m_stable = 0; m_locked = 0;
          end else begin
            if (m_stable < LW) m_stable++;
            m_locked = (m_stable == LW);
          end
          foreach (h[i]) h[i] = 0;
          m_run = 0;
        end else m_run++;
      end
    end
  end
  always @(negedge clk) begin
    check("phase", phase, m_phase);
    check("locked", locked, m_locked);
    check("phase_upd", phase_upd, m_upd);
    if (phase_upd) pulses++;
  end
  task automatic window(input int ea, input int ca, input int eb, input int cb);
    int t = 0;
    while (m_run != 0 && t < 200) begin @(negedge clk); t++; end
    if (m_run != 0) begin total++; $display("FAIL window_sync: run %0d expected 0", m_run); end
    for (int c = 0; c <= LAST; c++) begin
      logic [7:0] tr;
      tr = '0;
      if (c < ca) tr[ea] = 1'b1;
      if (c < cb) tr[eb] = 1'b1;
      trans = tr;
      @(negedge clk);
    end
  endtask
  initial begin
    int e, e2;
    logic [7:0] tr;
    enable = 1; trans = 8'hFF;
    #1 reset_n = 0;
    repeat (4) @(negedge clk);
    check("rst_phase", phase, 0);
    check("rst_locked", locked, 0);
    check("rst_upd", phase_upd, 0);
    trans = 8'h08; reset_n = 1;
    repeat (25) @(negedge clk);
    check("t2_hold", phase, 0);
    @(negedge clk);
    check("t2_phase", phase, 7);
    check("t2_pulse", phase_upd, 1);
    repeat (75) @(negedge clk);
    check("t2_not_locked", locked, 0);
    repeat (25) @(negedge clk);
    check("t2_locked", locked, 1);
    check("t2_pulses", pulses, 1);
    window(4, 9, 3, 7);
    check("hyst_stay_phase", phase, 7);
    check("hyst_stay_locked", locked, 1);
    window(4, 10, 3, 7);
    check("hyst_edge_stay", phase, 7);
    window(4, 12, 3, 3);
    check("hyst_move_phase", phase, 0);
    check("hyst_move_pulse", phase_upd, 1);
    check("hyst_move_locked", locked, 0);
    window(3, 11, 4, 7);
    check("hyst_edge_move", phase, 7);
    repeat (5) window(3, 16, 3, 16);
    check("nd_pre_locked", locked, 1);
    window(0, 0, 0, 0);
    check("nd_locked", locked, 0);
    check("nd_phase", phase, 7);
    check("nd_upd", phase_upd, 0);
    repeat (4) window(3, 16, 3, 16);
    check("c_relock", locked, 1);
    trans = 8'h08;
    repeat (5) @(negedge clk);
    enable = 0;
    @(negedge clk);
    check("c_drop_locked", locked, 0);
    enable = 1; force_en = 1; force_phase = 3;
    @(negedge clk);
    check("c_force_phase", phase, 3);
    check("c_force_upd", phase_upd, 0);
    repeat (2) @(negedge clk);
    force_en = 0;
    repeat (25) @(negedge clk);
    check("c_release_hold", phase, 3);
    @(negedge clk);
    check("c_release_phase", phase, 7);
    check("c_release_pulse", phase_upd, 1);
    trans = 8'h22;
    #1 reset_n = 0;
    repeat (2) @(negedge clk);
    reset_n = 1;
    repeat (26) @(negedge clk);
    check("tie_phase", phase, 5);
    e = 0; e2 = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 90 == 0) begin e = $urandom_range(0, 7); e2 = $urandom_range(0, 7); end
      for (int i = 0; i < 8; i++)
        tr[i] = (i == e) ? ($urandom_range(0, 7) != 0) : (i == e2) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 15) == 0);
      trans = tr;
      enable = $urandom_range(0, 249) != 0;
      force_en = $urandom_range(0, 399) == 0;
      force_phase = 3'($urandom);
      reset_n = 1;
      if ($urandom_range(0, 1499) == 0) #1 reset_n = 0;
      @(negedge clk);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
